// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the data port and the memory-side
// port of mem_arbiter.
//   fetch : if_req/if_addr in, if_gnt/if_rvalid/if_rdata/if_err out
//   data  : d_req/d_we/d_addr/d_wdata/d_size/d_unsigned in,
//           d_gnt/d_rvalid/d_rdata/d_err out
//   memory: mem_addr/mem_wdata/mem_we/mem_size/mem_rdun out, mem_rdata in
// slave  = arbiter view; master = requesters plus memory (environment view).
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic        mem_rdun;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata, if_err,
      input  d_req, d_we, d_addr, d_wdata, d_size, d_unsigned,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_addr, mem_wdata, mem_we, mem_size, mem_rdun,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      output d_req, d_we, d_addr, d_wdata, d_size, d_unsigned,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_addr, mem_wdata, mem_we, mem_size, mem_rdun,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between an instruction-fetch port and a
// data port sharing one memory with a combinational read and a posedge write.
// Fixed latency: grant in cycle N, memory access in N+1, rvalid in N+2.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - mem_arbiter_if.slave (fetch, data and memory-side signals)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | memory parked; may grant one pending request this cycle
// SERVE_I | memory driven from latched fetch fields
// SERVE_D | memory driven from latched data fields
module mem_arbiter #(
   parameter logic [31:0] START_ADDR = 32'h0100_0000,
   parameter logic [31:0] MEM_SIZE   = 32'd1048576
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t      state;
   logic        last_d;        // 1 when the data port was served last
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_unsigned;
   logic        lat_err;

   logic        gnt_i;
   logic        gnt_d;
   logic        if_rvalid_q;
   logic        if_err_q;
   logic [31:0] if_rdata_q;
   logic        d_rvalid_q;
   logic        d_err_q;
   logic [31:0] d_rdata_q;

   // 33-bit arithmetic so addr+bytes near 2^32 cannot wrap into range.
   function automatic logic access_bad(input logic [31:0] addr, input logic [1:0] size);
      logic        bad;
      logic [32:0] nbytes;
      bad    = 1'b0;
      nbytes = 33'd1;
      case (size)
         2'b00: nbytes = 33'd1;
         2'b01: begin
            nbytes = 33'd2;
            if (addr[0]) bad = 1'b1;
         end
         2'b10: begin
            nbytes = 33'd4;
            if (addr[1:0] != 2'b00) bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      if ({1'b0, addr} < {1'b0, START_ADDR}) bad = 1'b1;
      if (({1'b0, addr} + nbytes) > ({1'b0, START_ADDR} + {1'b0, MEM_SIZE})) bad = 1'b1;
      return bad;
   endfunction

   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (!reset && state == IDLE) begin
         if (bus.if_req && bus.d_req) begin
            if (last_d) gnt_i = 1'b1;
            else        gnt_d = 1'b1;
         end else if (bus.if_req) begin
            gnt_i = 1'b1;
         end else if (bus.d_req) begin
            gnt_d = 1'b1;
         end
      end
   end

   assign bus.if_gnt    = gnt_i;
   assign bus.d_gnt     = gnt_d;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_err    = if_err_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_err     = d_err_q;
   assign bus.d_rdata   = d_rdata_q;

   always_comb begin
      bus.mem_addr  = START_ADDR;
      bus.mem_wdata = 32'h0;
      bus.mem_we    = 1'b0;
      bus.mem_size  = 2'b10;
      bus.mem_rdun  = 1'b0;
      case (state)
         SERVE_I: bus.mem_addr = lat_addr;
         SERVE_D: begin
            bus.mem_addr  = lat_addr;
            bus.mem_wdata = lat_wdata;
            // reset gates the strobe immediately so an abandoned write never lands
            bus.mem_we    = lat_we && !lat_err && !reset;
            bus.mem_size  = lat_size;
            bus.mem_rdun  = lat_unsigned;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_d       <= 1'b1;
         lat_addr     <= 32'h0;
         lat_wdata    <= 32'h0;
         lat_we       <= 1'b0;
         lat_size     <= 2'b10;
         lat_unsigned <= 1'b0;
         lat_err      <= 1'b0;
         if_rvalid_q  <= 1'b0;
         if_err_q     <= 1'b0;
         if_rdata_q   <= 32'h0;
         d_rvalid_q   <= 1'b0;
         d_err_q      <= 1'b0;
         d_rdata_q    <= 32'h0;
      end else begin
         if_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_err_q     <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_i) begin
                  lat_addr     <= bus.if_addr;
                  lat_wdata    <= 32'h0;
                  lat_we       <= 1'b0;
                  lat_size     <= 2'b10;
                  lat_unsigned <= 1'b0;
                  lat_err      <= access_bad(bus.if_addr, 2'b10);
                  last_d       <= 1'b0;
                  state        <= SERVE_I;
               end else if (gnt_d) begin
                  lat_addr     <= bus.d_addr;
                  lat_wdata    <= bus.d_wdata;
                  lat_we       <= bus.d_we;
                  lat_size     <= bus.d_size;
                  lat_unsigned <= bus.d_unsigned;
                  lat_err      <= access_bad(bus.d_addr, bus.d_size);
                  last_d       <= 1'b1;
                  state        <= SERVE_D;
               end
            end
            SERVE_I: begin
               if_rvalid_q <= 1'b1;
               if_err_q    <= lat_err;
               if_rdata_q  <= lat_err ? 32'h0 : bus.mem_rdata;
               state       <= IDLE;
            end
            SERVE_D: begin
               d_rvalid_q <= 1'b1;
               d_err_q    <= lat_err;
               d_rdata_q  <= (lat_err || lat_we) ? 32'h0 : bus.mem_rdata;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   localparam logic [31:0] START = 32'h0100_0000;

   logic clk;
   logic reset;
   logic preload;
   int   n_vec;
   int   n_err;
   int   we_cnt;

   mem_arbiter_if bus ();

   mem_arbiter #(.START_ADDR(START), .MEM_SIZE(32'd1048576)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: 256 words, index wraps; memory does sizing and extension
   logic [31:0] mem [0:255];

   function automatic logic [7:0] widx(input logic [31:0] a);
      logic [31:0] off;
      off = (a - START) >> 2;
      return off[7:0];
   endfunction

   always_comb begin
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      w = mem[widx(bus.mem_addr)];
      b = 8'(w >> {bus.mem_addr[1:0], 3'b000});
      h = 16'(w >> {bus.mem_addr[1], 4'b0000});
      case (bus.mem_size)
         2'b00:   bus.mem_rdata = bus.mem_rdun ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   bus.mem_rdata = bus.mem_rdun ? {16'h0, h} : {{16{h[15]}}, h};
         default: bus.mem_rdata = w;
      endcase
   end

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[0]   <= 32'h0050_0093;
         mem[8]   <= 32'h1111_1111;
         mem[255] <= 32'hCAFE_F00D;
      end else if (bus.mem_we) begin
         case (bus.mem_size)
            2'b00:   mem[widx(bus.mem_addr)][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_wdata[7:0];
            2'b01:   mem[widx(bus.mem_addr)][{bus.mem_addr[1], 4'b0000} +: 16] <= bus.mem_wdata[15:0];
            default: mem[widx(bus.mem_addr)] <= bus.mem_wdata;
         endcase
      end
   end

   always @(negedge clk) if (bus.mem_we === 1'b1) we_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [16];

   // one isolated transaction: grant cycle 0, access cycle 1, rvalid cycle 2
   task automatic run_vec(input int k, input vec_t v);
      int    we0;
      string tag;
      tag = $sformatf("v%0d", k);
      we0 = we_cnt;
      if (v.is_d) begin
         bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
         bus.d_wdata = v.wdata; bus.d_size = v.size; bus.d_unsigned = v.uns;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = v.addr;
      end
      @(negedge clk);
      chk({tag, " gnt"}, {30'h0, bus.if_gnt, bus.d_gnt}, v.is_d ? 32'd1 : 32'd2);
      step();
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      @(negedge clk);
      chk({tag, " serve gnt"}, {30'h0, bus.if_gnt, bus.d_gnt}, 32'd0);
      chk({tag, " mem_addr"}, bus.mem_addr, v.addr);
      step();
      @(negedge clk);
      if (v.is_d) begin
         chk({tag, " rvalid"}, {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'd1);
         chk({tag, " rdata"}, bus.d_rdata, v.exp_rdata);
         chk({tag, " err"}, {31'h0, bus.d_err}, {31'h0, v.exp_err});
      end else begin
         chk({tag, " rvalid"}, {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'd2);
         chk({tag, " rdata"}, bus.if_rdata, v.exp_rdata);
         chk({tag, " err"}, {31'h0, bus.if_err}, {31'h0, v.exp_err});
      end
      chk({tag, " we cycles"}, we_cnt - we0, (v.we && v.is_d && !v.exp_err) ? 32'd1 : 32'd0);
      step();
      @(negedge clk);
      chk({tag, " rvalid drop"}, {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
      chk({tag, " rdata hold"}, v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
      step();
   endtask

   initial begin
      n_vec = 0; n_err = 0; we_cnt = 0;
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      bus.d_size = 2'b10; bus.d_unsigned = 1'b0;

      //          is_d we  addr           wdata          size   uns  exp_rdata      err
      vecs[0]  = '{1'b0, 1'b0, 32'h0100_0000, 32'h0,         2'b10, 1'b0, 32'h0050_0093, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 32'h0100_0010, 32'h0000_00A5, 2'b00, 1'b0, 32'h0,         1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0100_0010, 32'h0,         2'b00, 1'b0, 32'hFFFF_FFA5, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0100_0010, 32'h0,         2'b00, 1'b1, 32'h0000_00A5, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 32'h0100_0012, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0,         1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'h0100_0010, 32'h0,         2'b10, 1'b0, 32'hBEEF_00A5, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h0100_0012, 32'h0,         2'b01, 1'b0, 32'hFFFF_BEEF, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0100_0012, 32'h0,         2'b01, 1'b1, 32'h0000_BEEF, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0100_0002, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1};
      vecs[9]  = '{1'b1, 1'b0, 32'h0110_0000, 32'h0,         2'b01, 1'b0, 32'h0,         1'b1};
      vecs[10] = '{1'b1, 1'b0, 32'h0100_0010, 32'h0,         2'b11, 1'b0, 32'h0,         1'b1};
      vecs[11] = '{1'b1, 1'b1, 32'h0100_0011, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         1'b1};
      vecs[12] = '{1'b0, 1'b0, 32'h00FF_FFFC, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1};
      vecs[13] = '{1'b1, 1'b0, 32'h010F_FFFC, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 32'h0100_0010, 32'h0,         2'b10, 1'b0, 32'hBEEF_00A5, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 32'h0100_0002, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1};

      // reset with a request pending: nothing may be granted or driven
      reset = 1'b1; preload = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = START;
      step();
      preload = 1'b0;
      @(negedge clk);
      chk("reset gnt", {30'h0, bus.if_gnt, bus.d_gnt}, 32'd0);
      chk("reset rvalid", {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
      chk("reset err", {30'h0, bus.if_err, bus.d_err}, 32'd0);
      chk("reset if_rdata", bus.if_rdata, 32'h0);
      chk("reset d_rdata", bus.d_rdata, 32'h0);
      chk("reset mem_we", {31'h0, bus.mem_we}, 32'd0);
      chk("reset mem_addr", bus.mem_addr, START);
      chk("reset mem_size", {30'h0, bus.mem_size}, 32'd2);
      bus.if_req = 1'b0;
      step();
      reset = 1'b0;

      for (int k = 0; k < 16; k++) run_vec(k, vecs[k]);

      // tie after reset: fetch first, then strict alternation every 2 cycles
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = START;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0100_0010;
      bus.d_size = 2'b10; bus.d_unsigned = 1'b0;
      for (int k = 0; k < 8; k++) begin
         logic ei, ed;
         ei = (k % 2 == 0) && ((k / 2) % 2 == 0);
         ed = (k % 2 == 0) && ((k / 2) % 2 == 1);
         @(negedge clk);
         chk($sformatf("tie gnt c%0d", k), {30'h0, bus.if_gnt, bus.d_gnt}, {30'h0, ei, ed});
         if (k == 2) chk("tie if_rdata", bus.if_rdata, 32'h0050_0093);
         if (k == 4) chk("tie d_rdata", bus.d_rdata, 32'hBEEF_00A5);
         step();
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      repeat (3) step();

      // reset during SERVE_D of a word write: no write, no rvalid, back to IDLE
      begin
         int we0;
         we0 = we_cnt;
         bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0100_0020;
         bus.d_wdata = 32'h1234_5678; bus.d_size = 2'b10;
         @(negedge clk);
         chk("rst-op gnt", {31'h0, bus.d_gnt}, 32'd1);
         step();
         bus.d_req = 1'b0; reset = 1'b1;
         @(negedge clk);
         chk("rst-op mem_we", {31'h0, bus.mem_we}, 32'd0);
         step();
         reset = 1'b0;
         @(negedge clk);
         chk("rst-op rvalid", {31'h0, bus.d_rvalid}, 32'd0);
         chk("rst-op idle addr", bus.mem_addr, START);
         step();
         @(negedge clk);
         chk("rst-op rvalid2", {31'h0, bus.d_rvalid}, 32'd0);
         chk("rst-op we cycles", we_cnt - we0, 32'd0);
         chk("rst-op mem", mem[8], 32'h1111_1111);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
